// File: rtl/duty_ramp_if.sv
// Command handshake between the duty-cycle source and the ramp stage.
interface duty_ramp_if #(
  parameter int DUTY_WIDTH = 8
);
  logic [DUTY_WIDTH-1:0] cmd_duty;
  logic                  cmd_valid;
  logic                  cmd_ready;

  modport master (output cmd_duty, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_duty, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/duty_ramp.sv
// Slew-limited duty-cycle conditioner with command watchdog and illegal-hall shutdown,
// sitting directly upstream of the motor driver's duty_cycle input.
module duty_ramp #(
  parameter int DUTY_WIDTH     = 8,
  parameter int STEP           = 4,
  parameter int TICK_DIV       = 1000,
  parameter int WDOG_TICKS     = 100,
  parameter int HALL_FAULT_CYC = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  duty_ramp_if.slave            cmd_if,
  input  logic [2:0]            h,
  input  logic                  fault_clear,
  output logic [DUTY_WIDTH-1:0] duty_cycle,
  output logic                  wdog_timeout,
  output logic                  hall_fault
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int WW = $clog2(WDOG_TICKS + 1);
  localparam int HW = $clog2(HALL_FAULT_CYC + 1);
  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0]       WDOG_LAST = WW'(WDOG_TICKS - 1);
  localparam logic [WW-1:0]       WDOG_MAX  = WW'(WDOG_TICKS);
  localparam logic [HW-1:0]       HALL_LAST = HW'(HALL_FAULT_CYC - 1);
  localparam logic [HW-1:0]       HALL_MAX  = HW'(HALL_FAULT_CYC);
  localparam logic [DUTY_WIDTH:0] STEP_W    = (DUTY_WIDTH + 1)'(STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, HOLD = 2'd2, FAULT = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d, target_q, target_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [WW-1:0]         wdog_cnt_q, wdog_cnt_d;
  logic [HW-1:0]         hall_cnt_q, hall_cnt_d;
  logic [2:0]            h_meta_q, h_meta_d, h_sync_q, h_sync_d;
  logic                  ready_q, ready_d, wdog_to_q, wdog_to_d, hall_fault_q, hall_fault_d;
  logic                  tick_s, accept_s, illegal_s, fault_fire_s;

  // Move at most STEP toward the target; the 9-bit difference keeps it from overshooting or wrapping.
  function automatic logic [DUTY_WIDTH-1:0] ramp_next(input logic [DUTY_WIDTH-1:0] cur,
                                                      input logic [DUTY_WIDTH-1:0] tgt);
    logic [DUTY_WIDTH:0] diff;
    logic [DUTY_WIDTH:0] step;
    diff = '0;
    step = '0;
    ramp_next = cur;
    if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      step = (diff > STEP_W) ? STEP_W : diff;
      ramp_next = cur + step[DUTY_WIDTH-1:0];
    end else if (tgt < cur) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      step = (diff > STEP_W) ? STEP_W : diff;
      ramp_next = cur - step[DUTY_WIDTH-1:0];
    end else begin
      ramp_next = cur;
    end
  endfunction

  function automatic state_t classify(input logic [DUTY_WIDTH-1:0] d, input logic [DUTY_WIDTH-1:0] t);
    if (d != t)            classify = RAMP;
    else if (d == '0)      classify = IDLE;
    else                   classify = HOLD;
  endfunction

  // Next-state logic: hall fault outranks everything, an accepted command outranks watchdog expiry.
  always_comb begin
    h_meta_d     = h;
    h_sync_d     = h_meta_q;
    state_d      = state_q;
    duty_d       = duty_q;
    target_d     = target_q;
    wdog_cnt_d   = wdog_cnt_q;
    wdog_to_d    = wdog_to_q;
    hall_fault_d = hall_fault_q;

    illegal_s    = (h_sync_q == 3'b000) || (h_sync_q == 3'b111);
    tick_s       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d   = tick_s ? '0 : tick_cnt_q + TW'(1);
    accept_s     = cmd_if.cmd_valid && ready_q;
    fault_fire_s = illegal_s && (hall_cnt_q == HALL_LAST);

    if (!illegal_s)                hall_cnt_d = '0;
    else if (hall_cnt_q != HALL_MAX) hall_cnt_d = hall_cnt_q + HW'(1);
    else                           hall_cnt_d = hall_cnt_q;

    if (fault_fire_s) begin
      duty_d       = '0;
      target_d     = '0;
      hall_fault_d = 1'b1;
      state_d      = FAULT;
    end else if (state_q == FAULT) begin
      if (fault_clear && !illegal_s) begin
        hall_fault_d = 1'b0;
        state_d      = IDLE;
      end else begin
        state_d      = FAULT;
      end
    end else begin
      // A tick on the acceptance cycle still ramps toward the previous target.
      if (tick_s) duty_d = ramp_next(duty_q, target_q);
      else        duty_d = duty_q;

      if (accept_s) begin
        target_d   = cmd_if.cmd_duty;
        wdog_cnt_d = '0;
        wdog_to_d  = 1'b0;
      end else if (tick_s && (wdog_cnt_q != WDOG_MAX)) begin
        wdog_cnt_d = wdog_cnt_q + WW'(1);
        if (wdog_cnt_q == WDOG_LAST) begin
          target_d  = '0;
          wdog_to_d = 1'b1;
        end else begin
          wdog_to_d = wdog_to_q;
        end
      end else begin
        wdog_cnt_d = wdog_cnt_q;
      end
      state_d = classify(duty_d, target_d);
    end

    ready_d = (state_d != FAULT);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      target_q     <= '0;
      tick_cnt_q   <= '0;
      wdog_cnt_q   <= '0;
      hall_cnt_q   <= '0;
      h_meta_q     <= 3'b000;
      h_sync_q     <= 3'b000;
      ready_q      <= 1'b1;
      wdog_to_q    <= 1'b0;
      hall_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      tick_cnt_q   <= tick_cnt_d;
      wdog_cnt_q   <= wdog_cnt_d;
      hall_cnt_q   <= hall_cnt_d;
      h_meta_q     <= h_meta_d;
      h_sync_q     <= h_sync_d;
      ready_q      <= ready_d;
      wdog_to_q    <= wdog_to_d;
      hall_fault_q <= hall_fault_d;
    end
  end

  assign duty_cycle       = duty_q;
  assign wdog_timeout     = wdog_to_q;
  assign hall_fault       = hall_fault_q;
  assign cmd_if.cmd_ready = ready_q;
endmodule

// File: doc/duty_ramp.md
# duty_ramp

Command-conditioning stage directly upstream of the motor driver: accepts a requested duty cycle over a valid/ready handshake and slews its `duty_cycle` output toward it at a bounded rate. It feeds the motor driver's `duty_cycle` input. It forces the output to zero when commands stop arriving or when the hall inputs show an illegal code. It exists so a single bad or stale command cannot step full torque into the bridge.

## Interface
- `DUTY_WIDTH`, 8: width of duty values; must equal `DUTY_CYCLE_WIDTH` of the phase driver.
- `STEP`, 4: maximum change of `duty_cycle` per ramp tick, in LSBs; 1 ≤ STEP < 2^DUTY_WIDTH.
- `TICK_DIV`, 1000: clocks per ramp tick; ≥ 2.
- `WDOG_TICKS`, 100: ramp ticks without an accepted command before the watchdog fires; ≥ 1.
- `HALL_FAULT_CYC`, 16: consecutive clocks of an illegal synchronized hall code before a fault latches; ≥ 1.

- `clock`: in, 1, sole clock, rising edge.
- `reset_n`: in, 1, asynchronous active-low reset.
- `cmd_duty`: in, DUTY_WIDTH, requested duty, unsigned.
- `cmd_valid`: in, 1, `cmd_duty` is valid.
- `cmd_ready`: out, 1, block accepts a command this cycle.
- `h`: in, 3, raw hall inputs (asynchronous).
- `fault_clear`: in, 1, single-cycle pulse that clears a latched hall fault.
- `duty_cycle`: out, DUTY_WIDTH, ramped duty to the motor driver, registered.
- `wdog_timeout`: out, 1, sticky; set when the watchdog fires, cleared by the next accepted command.
- `hall_fault`: out, 1, latched illegal-hall fault.

## Operation
- Reset (async assert, sync release) values:
  - `duty_cycle`=0, internal `target`=0, `cmd_ready`=1, `wdog_timeout`=0, `hall_fault`=0.
  - Tick counter and watchdog counter = 0; hall synchronizer flops = 0; state IDLE.
- `h` passes through a 2-flop synchronizer. The code is illegal when the synchronized value is 3'b000 or 3'b111.
- Tick: a counter runs 0..TICK_DIV-1 and wraps. `tick` pulses for one cycle when the count equals TICK_DIV-1.
- Handshake: a command is accepted on a cycle with `cmd_valid && cmd_ready`. On acceptance:
  - `target` ← `cmd_duty`.
  - The watchdog counter clears and `wdog_timeout` clears.
  - Unaccepted commands are ignored, not queued.
- `cmd_ready` = 1 in every state except FAULT.
- Ramp on each tick (unsigned, no wrap):
  - if `target` > `duty_cycle`: `duty_cycle` += min(STEP, `target` − `duty_cycle`);
  - if `target` < `duty_cycle`: `duty_cycle` −= min(STEP, `duty_cycle` − `target`);
  - else unchanged.
  - The difference is computed at DUTY_WIDTH+1 bits. The output never overshoots `target` and never wraps past 0 or 2^DUTY_WIDTH−1.
- Watchdog:
  - Increments on each tick while not in FAULT. It saturates at WDOG_TICKS.
  - On reaching WDOG_TICKS: `target` ← 0 and `wdog_timeout` ← 1. The output then ramps down at STEP per tick; it does not drop to zero instantly.
- Hall fault:
  - An illegal code held for HALL_FAULT_CYC consecutive clocks sets `hall_fault`.
  - The same edge forces `duty_cycle` ← 0 and `target` ← 0. Enter FAULT.
  - A legal code resets the consecutive count.
- States:
  - IDLE: `duty_cycle`=0 and `target`=0.
  - RAMP: `duty_cycle` ≠ `target`.
  - HOLD: `duty_cycle` = `target` ≠ 0.
  - FAULT: `duty_cycle` held 0, `cmd_ready`=0, ticks ignored for ramping.
  - Transitions among IDLE/RAMP/HOLD follow the equalities above.
  - FAULT → IDLE on a `fault_clear` cycle only when the synchronized hall code is legal on that cycle. Otherwise stay in FAULT.
- Simultaneous events:
  - Accepted command and watchdog expiry on the same cycle: the command wins. `target` = `cmd_duty`, watchdog clears, `wdog_timeout` not set.
  - Accepted command and tick on the same cycle: that tick ramps toward the old `target`; the new `target` applies from the next tick.
  - Hall fault and anything else: the fault wins.

## Timing
- `duty_cycle` is registered and changes only on a tick edge or on a fault edge.
- Command acceptance to `target` updated: 1 clock. First output movement: at the next tick, worst case TICK_DIV clocks later.
- Full-scale slew: ceil((2^DUTY_WIDTH−1)/STEP) ticks.
- Hall pin to `duty_cycle`=0: 2 (sync) + HALL_FAULT_CYC clocks.
- `cmd_ready` falls on the same edge that enters FAULT and rises on the edge that leaves it.
- Reset mid-ramp: `duty_cycle` goes to 0 asynchronously. The tick phase restarts at 0.

## Test plan
- Params TICK_DIV=4, STEP=4, WDOG_TICKS=8. Command 10 from IDLE → `duty_cycle` 4, 8, 10 on three successive ticks, then HOLD at 10.
- Hold at 10, then command 0 → 6, 2, 0 on successive ticks; no underflow.
- Command 255 with STEP=4 → reaches 255 after 64 ticks without wrap. Command 250 → steps 255→251→250.
- Command 20, then no commands for 8 ticks → `wdog_timeout`=1 and ramp to 0 at 4/tick. A command landing on the expiry cycle → `wdog_timeout` stays 0.
- HALL_FAULT_CYC=3, `duty_cycle`=40, drive h=3'b111:
  - `hall_fault`=1 and `duty_cycle`=0 exactly 5 clocks later; `cmd_ready`=0.
  - `fault_clear` while h=3'b111 → no change.
  - h=3'b101 then `fault_clear` → IDLE, `cmd_ready`=1.
- Assert `reset_n`=0 mid-ramp at `duty_cycle`=12 → all outputs at reset values immediately, without waiting for a clock edge.
